// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for sequence_generator.
//   seq_state_e        - FSM state encoding
//   SEQ_PATTERN_10110  - default transmit pattern
//   seq_overlap_len()  - longest proper prefix that is also a suffix,
//                        evaluated at elaboration for overlap mode
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

    localparam logic [4:0] SEQ_PATTERN_10110 = 5'b10110;

    // pattern is right-aligned in 16 bits; width is 2..16
    function automatic int seq_overlap_len(input logic [15:0] pattern, input int width);
        logic [15:0] mask;
        logic [15:0] prefix;
        logic [15:0] suffix;
        int          best;
        best = 0;
        for (int k = 1; k < width; k++) begin
            mask   = (16'd1 << k) - 16'd1;
            prefix = (pattern >> (width - k)) & mask;
            suffix = pattern & mask;
            if (prefix == suffix) best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_pattern_shifter.sv
// seq_pattern_shifter: PATTERN_W-bit shift register plus bit counter.
//   clk, rst_n   clock, synchronous active-low reset
//   load         reload PATTERN (shifted left by load_ofs), counter = load_ofs
//   shift        shift left one bit, counter + 1 (load has priority)
//   load_ofs     number of leading pattern bits to skip on load
//   msb          bit currently at the head of the register
//   last_bit     head bit is the final bit of the pattern
module seq_pattern_shifter
    import seq_pkg::*;
#(
    parameter int                   PATTERN_W = 5,
    parameter logic [PATTERN_W-1:0] PATTERN   = SEQ_PATTERN_10110,
    localparam int                  CW        = $clog2(PATTERN_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          shift,
    input  logic [CW-1:0] load_ofs,
    output logic          msb,
    output logic          last_bit
);

    logic [PATTERN_W-1:0] sreg_q;
    logic [CW-1:0]        cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            sreg_q <= PATTERN << load_ofs;
            cnt_q  <= load_ofs;
        end else if (shift) begin
            sreg_q <= {sreg_q[PATTERN_W-2:0], 1'b0};
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign msb      = sreg_q[PATTERN_W-1];
    assign last_bit = (cnt_q == CW'(PATTERN_W - 1));

endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter (MSB first), repeated
// repeat_cnt times with optional idle gaps between copies.
//   clk, rst_n   clock, synchronous active-low reset
//   start        burst request, sampled in IDLE only
//   repeat_cnt   copies to send, latched on accepted start
//   gap_len      idle cycles between copies, latched on accepted start
//   dout/dvalid  serial data and qualifier
//   frame_mark   pulse with the last bit of each copy
//   busy         burst in progress
//   done         one-cycle pulse after the burst
// Build option SEQ_GEN_OVERLAP_EN: copies after the first skip the
// prefix/suffix overlap of PATTERN, and gap_len is ignored.
//
// state   | meaning
// --------+--------------------------------------------
// S_IDLE  | waiting for start
// S_SHIFT | sending pattern bits
// S_GAP   | idle cycles between copies
// S_DONE  | burst finished, done pulse issued next edge
module sequence_generator
    import seq_pkg::*;
#(
    parameter int                   PATTERN_W = 5,
    parameter logic [PATTERN_W-1:0] PATTERN   = SEQ_PATTERN_10110,
    parameter int                   CNT_W     = 8,
    parameter int                   GAP_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             dout,
    output logic             dvalid,
    output logic             frame_mark,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(PATTERN_W);

    seq_state_e       state_q;
    logic [CNT_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_len_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             dout_q, dvalid_q, frame_q, busy_q, done_q;

    logic             sh_load, sh_shift, sh_msb, sh_last;
    logic             first_load;
    logic [CW-1:0]    sh_ofs;

`ifdef SEQ_GEN_OVERLAP_EN
    localparam int OVL = seq_overlap_len(16'(PATTERN), PATTERN_W);
    assign sh_ofs = first_load ? '0 : CW'(OVL);
`else
    assign sh_ofs = '0;
`endif

    // Reloads happen on acceptance, back-to-back copies, and gap expiry.
    always_comb begin
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        first_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (repeat_cnt != '0)) begin
                    sh_load    = 1'b1;
                    first_load = 1'b1;
                end
            end
            S_SHIFT: begin
                sh_shift = 1'b1;
                if (sh_last && (rep_q != CNT_W'(1)) && (gap_len_q == '0))
                    sh_load = 1'b1;
            end
            S_GAP: begin
                if (gap_cnt_q == '0) sh_load = 1'b1;
            end
            default: ;
        endcase
    end

    seq_pattern_shifter #(
        .PATTERN_W (PATTERN_W),
        .PATTERN   (PATTERN)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_ofs (sh_ofs),
        .msb      (sh_msb),
        .last_bit (sh_last)
    );

    // Outputs are registered from the current state, so they trail the
    // state register by one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            dout_q    <= 1'b0;
            dvalid_q  <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rep_q <= repeat_cnt;
`ifdef SEQ_GEN_OVERLAP_EN
                        gap_len_q <= '0;
`else
                        gap_len_q <= gap_len;
`endif
                        state_q <= (repeat_cnt != '0) ? S_SHIFT : S_DONE;
                    end
                end
                S_SHIFT: begin
                    dout_q   <= sh_msb;
                    dvalid_q <= 1'b1;
                    busy_q   <= 1'b1;
                    if (sh_last) begin
                        frame_q <= 1'b1;
                        rep_q   <= rep_q - CNT_W'(1);
                        if (rep_q == CNT_W'(1)) begin
                            state_q <= S_DONE;
                        end else if (gap_len_q != '0) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= gap_len_q - GAP_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    busy_q <= 1'b1;
                    if (gap_cnt_q == '0) state_q   <= S_SHIFT;
                    else                 gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dvalid     = dvalid_q;
    assign frame_mark = frame_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
module tb_sequence_generator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] repeat_cnt;
    logic [3:0] gap_len;
    logic       dout, dvalid, frame_mark, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] r_dout, r_dv, r_frame;
    int          c_busy, c_dv, c_frame, c_ones, done_at;
    logic        seen;

    sequence_generator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .dout       (dout),
        .dvalid     (dvalid),
        .frame_mark (frame_mark),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, then sample every cycle until done or max_cyc.
    // Sample index 1 is the cycle after the edge following acceptance.
    task automatic run_burst(input logic [7:0] rc, input logic [3:0] gl,
                             input int mid_start, input int max_cyc);
        int n;
        r_dout = '0; r_dv = '0; r_frame = '0;
        c_busy = 0; c_dv = 0; c_frame = 0; c_ones = 0; done_at = 0;
        seen = 1'b0;
        n = 0;
        start = 1'b1; repeat_cnt = rc; gap_len = gl;
        tick();
        start = 1'b0; repeat_cnt = 8'd7; gap_len = 4'd1;
        while (!seen && n < max_cyc) begin
            start = (mid_start > 0) && (n + 1 == mid_start);
            tick();
            n++;
            r_dout  = {r_dout[62:0], dout};
            r_dv    = {r_dv[62:0], dvalid};
            r_frame = {r_frame[62:0], frame_mark};
            c_busy  += int'(busy);
            c_dv    += int'(dvalid);
            c_frame += int'(frame_mark);
            c_ones  += int'(dout & dvalid);
            if (done) begin
                seen    = 1'b1;
                done_at = n;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        int act;
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            act += int'(busy | dvalid | done | frame_mark | dout);
        end
        check_eq(tag, 64'(act), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; repeat_cnt = '0; gap_len = '0;
        repeat (3) tick();
        check_eq("reset_outputs", 64'({dout, dvalid, frame_mark, busy, done}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-burst on the 4th bit
        start = 1'b1; repeat_cnt = 8'd3; gap_len = 4'd0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_eq("abort_4th_bit", 64'({dout, dvalid, busy}), 64'b111);
        rst_n = 1'b0;
        tick();
        check_eq("abort_outputs", 64'({dout, dvalid, frame_mark, busy, done}), 64'd0);
        rst_n = 1'b1;
        check_quiet("abort_no_done", 8);

        // Single copy
        run_burst(8'd1, 4'd0, 0, 20);
        check_eq("single_done_at", 64'(done_at), 64'd6);
        check_eq("single_dout",    r_dout,  64'(6'b101100));
        check_eq("single_dvalid",  r_dv,    64'(6'b111110));
        check_eq("single_frame",   r_frame, 64'(6'b000010));
        check_eq("single_busy",    64'(c_busy), 64'd5);
        check_quiet("single_idle_after", 3);

        // Gapped repeats
        run_burst(8'd2, 4'd3, 0, 40);
`ifdef SEQ_GEN_OVERLAP_EN
        check_eq("gap_done_at", 64'(done_at), 64'd9);
        check_eq("gap_dout",    r_dout,  64'(9'b101101100));
        check_eq("gap_dvalid",  r_dv,    64'(9'b111111110));
        check_eq("gap_frame",   r_frame, 64'(9'b000010010));
        check_eq("gap_busy",    64'(c_busy), 64'd8);
`else
        check_eq("gap_done_at", 64'(done_at), 64'd14);
        check_eq("gap_dout",    r_dout,  64'(14'b10110000101100));
        check_eq("gap_dvalid",  r_dv,    64'(14'b11111000111110));
        check_eq("gap_frame",   r_frame, 64'(14'b00001000000010));
        check_eq("gap_busy",    64'(c_busy), 64'd13);
`endif
        check_eq("gap_frames", 64'(c_frame), 64'd2);

        // Zero count
        tick();
        run_burst(8'd0, 4'd2, 0, 10);
        check_eq("zero_done_at", 64'(done_at), 64'd1);
        check_eq("zero_dvalid",  64'(c_dv), 64'd0);
        check_eq("zero_busy",    64'(c_busy), 64'd0);

        // Start pulsed mid-burst is ignored
        tick();
        run_burst(8'd1, 4'd0, 3, 20);
        check_eq("ign_done_at", 64'(done_at), 64'd6);
        check_eq("ign_dout",    r_dout, 64'(6'b101100));
        check_quiet("ign_no_requeue", 6);

`ifdef SEQ_GEN_OVERLAP_EN
        // Overlapped copies
        run_burst(8'd3, 4'd0, 0, 40);
        check_eq("ovl_done_at", 64'(done_at), 64'd12);
        check_eq("ovl_dout",    r_dout,  64'(12'b101101101100));
        check_eq("ovl_frame",   r_frame, 64'(12'b000010010010));
        check_eq("ovl_busy",    64'(c_busy), 64'd11);
`endif

        // Max count
        run_burst(8'd255, 4'd0, 0, 1400);
`ifdef SEQ_GEN_OVERLAP_EN
        check_eq("max_done_at", 64'(done_at), 64'd768);
        check_eq("max_busy",    64'(c_busy), 64'd767);
        check_eq("max_ones",    64'(c_ones), 64'd511);
`else
        check_eq("max_done_at", 64'(done_at), 64'd1276);
        check_eq("max_busy",    64'(c_busy), 64'd1275);
        check_eq("max_ones",    64'(c_ones), 64'd765);
`endif
        check_eq("max_frames", 64'(c_frame), 64'd255);
        check_quiet("max_idle_after", 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
